lfdb_port_sched: RTL and testbench
==================================

Name: lfdb_port_sched

Overview:
- Scheduler and entry manager for the single-port linefill data buffer SRAM (LFDB).
- Pre-allocates 4-beat LFDB entries to the MSHR.
- Arbitrates the one SRAM port between downstream fill-beat writes and RAM-bound drain bursts.
- Sequences each drain as a non-interruptible 4-beat read burst.
- Sits between the downstream response path, the request arbiter and the LFDB storage macro.

Parameters:
- ENTRY_NUM, 8, number of 4-beat line entries (power of 2).
- TAG_W, 6, ROB entry id width carried with a drain request.
- STARVE_MAX, 8, consecutive stalled fill cycles before reads are held off.

Ports:
- clk in 1: clock.
- rst in 1: asynchronous active-high reset.
- alloc_vld out 1: a FREE entry is offered.
- alloc_idx out $clog2(ENTRY_NUM): offered entry.
- alloc_rdy in 1: MSHR takes the offered entry.
- wr_vld in 1: fill beat valid.
- wr_entry in $clog2(ENTRY_NUM): target entry.
- wr_last in 1: final beat of the line.
- wr_rdy out 1: fill beat accepted.
- rd_vld in 1: drain request.
- rd_entry in $clog2(ENTRY_NUM): entry to drain.
- rd_tag in TAG_W: ROB id.
- rd_rdy out 1: drain request accepted.
- mem_en out 1: SRAM enable.
- mem_wr_en out 1: SRAM write.
- mem_addr out $clog2(ENTRY_NUM)+2: {entry, beat}.
- out_vld out 1: SRAM read data valid this cycle.
- out_beat out 2: beat number of the current read data.
- out_last out 1: final beat of the burst.
- out_tag out TAG_W: tag aligned with the read data.
- fill_done out 1: pulse when wr_last is accepted.
- fill_done_entry out $clog2(ENTRY_NUM): entry completed by the fill.
- drain_done out 1: pulse on the final beat out.
- drain_done_tag out TAG_W: tag of the drained entry.
- free_cnt out $clog2(ENTRY_NUM)+1: number of FREE entries.

Behaviour:
- Reset values:
  - All entries FREE; burst FSM IDLE; all counters 0.
  - All outputs 0, except free_cnt=ENTRY_NUM and alloc_vld=1.
- Per-entry state: FREE -> ALLOC (alloc handshake) -> FILLING (first wr beat) -> FULL (wr_last accepted) -> DRAIN (rd accepted) -> FREE (last beat read).
- Allocation:
  - alloc_idx is the lowest-index FREE entry, decoded from registered state.
  - An entry freed in cycle N is offerable in cycle N+1.
  - alloc_vld=0 when free_cnt==0.
- Fill:
  - One line streams at a time.
  - A 2-bit beat counter advances on each wr handshake and clears on wr_last.
  - Write address is {wr_entry, cnt}.
  - wr_last on a count other than 3 is a protocol error (assertion).
  - A write to an entry not in ALLOC/FILLING is an error (assertion).
- Burst FSM: IDLE / BURST.
  - In IDLE: rd_rdy = rd_vld && state[rd_entry]==FULL && !starve_hold.
  - On acceptance: go to BURST, latch entry and tag, and issue beat 0 in the same cycle.
  - Beats 1..3 follow on consecutive cycles; the FSM returns to IDLE after beat 3.
  - Back-to-back bursts are allowed: a new rd may be accepted in the cycle after beat 3.
- Port arbitration:
  - Read wins. wr_rdy = !(read beat this cycle).
  - mem_en = read beat | (wr_vld && wr_rdy).
  - mem_wr_en = !read beat.
- Starvation:
  - A counter increments each cycle with wr_vld && !wr_rdy and clears on any wr handshake.
  - At STARVE_MAX, starve_hold=1: no new burst is accepted until one fill beat is accepted.
  - An in-flight burst always completes.
- Read output latency is exactly 1 cycle: out_vld/out_beat/out_last/out_tag are registered copies of the issuing cycle's control.
  - The output has no backpressure; the consumer must accept every beat.
- drain_done is asserted with out_last, and the entry becomes FREE in that same cycle.
- Simultaneous events:
  - Alloc handshake and drain free in one cycle: free_cnt net change 0.
  - fill_done and rd_vld for the same entry in one cycle: rd_rdy=0 that cycle, and the request is accepted next cycle.
- rst asserted mid-burst or mid-fill: everything is aborted, no done pulses are issued, and the block returns to the reset state.

Optional Feature:
- LFDB_SCHED_CRIT_FIRST_EN
- Defined:
  - Adds input rd_beat[1:0], latched with the drain request.
  - The burst issues beats rd_beat, rd_beat+1, ... modulo 4, wrapping 3 -> 0.
  - out_last flags the 4th beat issued, not beat 3.
- Undefined: the port is absent and beats are always issued 0,1,2,3.

Decomposition:
- vector_cache_pkg gains:
  - LFDB_BEATS=4.
  - An entry-state enum {FREE, ALLOC, FILLING, FULL, DRAIN}.
  - lfdb_sched_rd_t {entry, tag, beat}.
- One sub-module: lfdb_entry_alloc.
  - Holds the state vector, lowest-free priority encoder and free_cnt.
  - The parent holds the burst FSM, the arbitration logic and the starvation counter.

Test Plan:
- Reset, alloc 3 entries, fill entry 0 with 4 beats -> mem_addr 0,1,2,3 with mem_wr_en=1; fill_done=1 with entry 0 on the 4th beat; free_cnt=5.
- rd entry 0, tag 0x15 -> mem_addr 0..3 read in 4 consecutive cycles; out_beat 0..3 one cycle later; out_last and drain_done with tag 0x15 on beat 3; free_cnt returns to 6.
- Continuous rd of FULL entries with wr_vld held -> wr_rdy stays 0 for 8 cycles; the next rd is held until one write is accepted; the current burst is never broken.
- rd_vld on a FILLING entry -> rd_rdy=0 until the cycle after fill_done.
- All 8 entries allocated -> alloc_vld=0; a drain completes -> alloc_vld=1 with that index the next cycle.
- With the macro defined, rd_beat=2 -> beat order 2,3,0,1, out_last on beat 1. Separately, assert rst mid-burst -> no drain_done pulse and free_cnt=8.

Source files
------------

// File: rtl/vector_cache_pkg.sv
// -----------------------------------------------------------------------------
// vector_cache_pkg
// Shared types and constants for the vector cache linefill data buffer (LFDB).
//   LFDB_BEATS         : beats per LFDB line entry
//   LFDB_ENTRY_NUM     : default entry count of the LFDB
//   LFDB_TAG_W         : default ROB id width carried with a drain
//   lfdb_entry_state_e : per-entry lifecycle state
//   lfdb_sched_rd_t    : latched drain request {entry, tag, beat}
//   lfdb_next_beat     : modulo-4 beat increment
// -----------------------------------------------------------------------------
package vector_cache_pkg;

    localparam int LFDB_BEATS     = 4;
    localparam int LFDB_ENTRY_NUM = 8;
    localparam int LFDB_ENTRY_W   = $clog2(LFDB_ENTRY_NUM);
    localparam int LFDB_TAG_W     = 6;

    typedef enum logic [2:0] {
        LFDB_FREE    = 3'd0,
        LFDB_ALLOC   = 3'd1,
        LFDB_FILLING = 3'd2,
        LFDB_FULL    = 3'd3,
        LFDB_DRAIN   = 3'd4
    } lfdb_entry_state_e;

    typedef struct packed {
        logic [LFDB_ENTRY_W-1:0] entry;
        logic [LFDB_TAG_W-1:0]   tag;
        logic [1:0]              beat;
    } lfdb_sched_rd_t;

    // Beat numbers wrap 3 -> 0 so a critical-first burst still covers the line.
    function automatic logic [1:0] lfdb_next_beat(input logic [1:0] beat);
        return beat + 2'd1;
    endfunction

endpackage

// File: rtl/lfdb_entry_alloc.sv
// -----------------------------------------------------------------------------
// lfdb_entry_alloc
// Per-entry state vector of the LFDB, lowest-free allocator and free counter.
//   clk, rst      : clock, asynchronous active-high reset
//   alloc_vld/idx : a FREE entry is offered (lowest index) / its index
//   alloc_rdy     : MSHR takes the offered entry
//   fill_vld      : accepted fill beat for fill_entry, fill_last = final beat
//   drain_vld     : drain accepted for drain_entry (FULL -> DRAIN)
//   free_vld      : last beat of drain_entry's burst delivered (DRAIN -> FREE)
//   state         : registered per-entry state
//   free_cnt      : number of FREE entries
// -----------------------------------------------------------------------------
module lfdb_entry_alloc
    import vector_cache_pkg::*;
#(
    parameter int ENTRY_NUM = LFDB_ENTRY_NUM,
    parameter int EW        = $clog2(ENTRY_NUM)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              alloc_vld,
    output logic [EW-1:0]     alloc_idx,
    input  logic              alloc_rdy,
    input  logic              fill_vld,
    input  logic [EW-1:0]     fill_entry,
    input  logic              fill_last,
    input  logic              drain_vld,
    input  logic [EW-1:0]     drain_entry,
    input  logic              free_vld,
    input  logic [EW-1:0]     free_entry,
    output lfdb_entry_state_e state [ENTRY_NUM],
    output logic [EW:0]       free_cnt
);

    logic          alloc_hs_s;
    logic [EW-1:0] low_free_s;

    // Lowest-index FREE entry; scanning downwards lets the lowest match win.
    always_comb begin
        low_free_s = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            low_free_s = (state[i] == LFDB_FREE) ? EW'(i) : low_free_s;
        end
    end

    assign alloc_vld  = (free_cnt != '0);
    assign alloc_idx  = low_free_s;
    assign alloc_hs_s = alloc_vld && alloc_rdy;

    // Entry lifecycle; the four events act on disjoint states, so no priority is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                state[i] <= LFDB_FREE;
            end
        end else begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                case (state[i])
                    LFDB_FREE: begin
                        if (alloc_hs_s && (low_free_s == EW'(i))) state[i] <= LFDB_ALLOC;
                    end
                    LFDB_ALLOC, LFDB_FILLING: begin
                        if (fill_vld && (fill_entry == EW'(i)))
                            state[i] <= fill_last ? LFDB_FULL : LFDB_FILLING;
                    end
                    LFDB_FULL: begin
                        if (drain_vld && (drain_entry == EW'(i))) state[i] <= LFDB_DRAIN;
                    end
                    LFDB_DRAIN: begin
                        if (free_vld && (free_entry == EW'(i))) state[i] <= LFDB_FREE;
                    end
                    default: state[i] <= LFDB_FREE;
                endcase
            end
        end
    end

    // Free entry count; an allocation and a free in the same cycle cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_cnt <= (EW+1)'(ENTRY_NUM);
        end else begin
            case ({alloc_hs_s, free_vld})
                2'b10:   free_cnt <= free_cnt - (EW+1)'(1);
                2'b01:   free_cnt <= free_cnt + (EW+1)'(1);
                default: free_cnt <= free_cnt;
            endcase
        end
    end

endmodule

// File: rtl/lfdb_port_sched_chk.sv
// -----------------------------------------------------------------------------
// lfdb_port_sched_chk
// Protocol checks on the fill stream of the LFDB scheduler.
//   clk, rst  : clock, asynchronous active-high reset
//   wr_hs     : fill beat accepted this cycle
//   wr_last   : accepted beat claims to be the last of the line
//   fill_cnt  : beat counter value used for the accepted beat
//   wr_state  : current state of the entry being written
// -----------------------------------------------------------------------------
module lfdb_port_sched_chk
    import vector_cache_pkg::*;
(
    input logic              clk,
    input logic              rst,
    input logic              wr_hs,
    input logic              wr_last,
    input logic [1:0]        fill_cnt,
    input lfdb_entry_state_e wr_state
);

    // Fill protocol: last only on beat 3, writes only into entries being filled.
    always @(posedge clk) begin
        if (!rst && wr_hs) begin
            last_on_beat3: assert (!wr_last || (fill_cnt == 2'd3));
            write_target_ok: assert ((wr_state == LFDB_ALLOC) || (wr_state == LFDB_FILLING));
        end
    end

endmodule

// File: rtl/lfdb_port_sched.sv
// -----------------------------------------------------------------------------
// lfdb_port_sched
// Scheduler for the single-port LFDB SRAM: hands out 4-beat entries to the
// MSHR, streams fill beats in, and drains FULL entries as non-interruptible
// 4-beat read bursts. Reads own the port; a starvation counter holds off new
// bursts once fills have been blocked for STARVE_MAX cycles.
// Optional build macro: LFDB_SCHED_CRIT_FIRST_EN adds rd_beat, the first beat
// of the burst (wrapping modulo 4); without it bursts always start at beat 0.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   alloc_vld/idx/rdy         : entry offer to the MSHR
//   wr_vld/entry/last, wr_rdy : fill beat stream (wr_rdy = beat accepted)
//   rd_vld/entry/tag, rd_rdy  : drain request (rd_rdy = request accepted)
//   rd_beat                   : first beat of the burst (macro only)
//   mem_en/wr_en/addr         : SRAM control, addr = {entry, beat}
//   out_vld/beat/last/tag     : read data sideband, one cycle after issue
//   fill_done[_entry]         : pulse when wr_last is accepted
//   drain_done[_tag]          : pulse with the final beat out
//   free_cnt                  : number of FREE entries
// -----------------------------------------------------------------------------
module lfdb_port_sched
    import vector_cache_pkg::*;
#(
    parameter int ENTRY_NUM  = LFDB_ENTRY_NUM,
    parameter int TAG_W      = LFDB_TAG_W,
    parameter int STARVE_MAX = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         alloc_vld,
    output logic [$clog2(ENTRY_NUM)-1:0] alloc_idx,
    input  logic                         alloc_rdy,
    input  logic                         wr_vld,
    input  logic [$clog2(ENTRY_NUM)-1:0] wr_entry,
    input  logic                         wr_last,
    output logic                         wr_rdy,
    input  logic                         rd_vld,
    input  logic [$clog2(ENTRY_NUM)-1:0] rd_entry,
    input  logic [TAG_W-1:0]             rd_tag,
`ifdef LFDB_SCHED_CRIT_FIRST_EN
    input  logic [1:0]                   rd_beat,
`endif
    output logic                         rd_rdy,
    output logic                         mem_en,
    output logic                         mem_wr_en,
    output logic [$clog2(ENTRY_NUM)+1:0] mem_addr,
    output logic                         out_vld,
    output logic [1:0]                   out_beat,
    output logic                         out_last,
    output logic [TAG_W-1:0]             out_tag,
    output logic                         fill_done,
    output logic [$clog2(ENTRY_NUM)-1:0] fill_done_entry,
    output logic                         drain_done,
    output logic [TAG_W-1:0]             drain_done_tag,
    output logic [$clog2(ENTRY_NUM):0]   free_cnt
);

    localparam int EW = $clog2(ENTRY_NUM);
    localparam int SW = $clog2(STARVE_MAX + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]        burst_r;
    lfdb_sched_rd_t    cur_r;
    logic [1:0]        cnt_r;
    logic [1:0]        fill_cnt_r;
    logic [SW-1:0]     starve_cnt_r;
    logic              out_vld_r;
    logic [1:0]        out_beat_r;
    logic              out_last_r;
    logic [TAG_W-1:0]  out_tag_r;
    logic [EW-1:0]     done_entry_r;

    lfdb_entry_state_e entry_state [ENTRY_NUM];
    lfdb_entry_state_e wr_state_s;
    logic [1:0]        start_beat_s;
    logic              starve_hold_s;
    logic              rd_ok_s;
    logic              wr_hs_s;
    logic              iss_vld_s;
    logic [EW-1:0]     iss_entry_s;
    logic [TAG_W-1:0]  iss_tag_s;
    logic [1:0]        iss_beat_s;
    logic              iss_last_s;

`ifdef LFDB_SCHED_CRIT_FIRST_EN
    assign start_beat_s = rd_beat;
`else
    assign start_beat_s = 2'd0;
`endif

    assign starve_hold_s = (starve_cnt_r == SW'(STARVE_MAX));
    assign wr_state_s    = entry_state[wr_entry];

    // Read issue: a new burst in IDLE issues its first beat immediately,
    // otherwise the in-flight burst issues its next beat.
    always_comb begin
        rd_ok_s     = (burst_r == S_IDLE) && rd_vld &&
                      (entry_state[rd_entry] == LFDB_FULL) && !starve_hold_s;
        iss_vld_s   = 1'b0;
        iss_entry_s = '0;
        iss_tag_s   = '0;
        iss_beat_s  = 2'd0;
        iss_last_s  = 1'b0;
        if (rd_ok_s) begin
            iss_vld_s   = 1'b1;
            iss_entry_s = rd_entry;
            iss_tag_s   = rd_tag;
            iss_beat_s  = start_beat_s;
        end else if (burst_r == S_BURST) begin
            iss_vld_s   = 1'b1;
            iss_entry_s = cur_r.entry;
            iss_tag_s   = cur_r.tag;
            iss_beat_s  = cur_r.beat;
            iss_last_s  = (cnt_r == 2'(LFDB_BEATS - 1));
        end else begin
            iss_vld_s   = 1'b0;
        end
    end

    // Reads own the port; a fill beat only goes through in a cycle without a read.
    assign wr_hs_s   = wr_vld && !iss_vld_s;
    assign wr_rdy    = wr_hs_s;
    assign rd_rdy    = rd_ok_s;
    assign mem_en    = iss_vld_s || wr_hs_s;
    assign mem_wr_en = wr_hs_s;
    assign mem_addr  = iss_vld_s ? {iss_entry_s, iss_beat_s} :
                       (wr_hs_s ? {wr_entry, fill_cnt_r} : '0);

    assign fill_done       = wr_hs_s && wr_last;
    assign fill_done_entry = fill_done ? wr_entry : '0;

    assign out_vld        = out_vld_r;
    assign out_beat       = out_beat_r;
    assign out_last       = out_last_r;
    assign out_tag        = out_tag_r;
    assign drain_done     = out_last_r;
    assign drain_done_tag = out_last_r ? out_tag_r : '0;

    // Burst FSM: latch the request on acceptance, then step through the remaining beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_r <= S_IDLE;
            cur_r   <= '0;
            cnt_r   <= 2'd0;
        end else if (rd_ok_s) begin
            burst_r <= S_BURST;
            cur_r   <= '{entry: rd_entry, tag: rd_tag, beat: lfdb_next_beat(start_beat_s)};
            cnt_r   <= 2'd1;
        end else if (burst_r == S_BURST) begin
            cur_r.beat <= lfdb_next_beat(cur_r.beat);
            cnt_r      <= cnt_r + 2'd1;
            burst_r    <= iss_last_s ? S_IDLE : S_BURST;
        end else begin
            burst_r <= S_IDLE;
        end
    end

    // Fill beat counter for the single line being streamed in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_cnt_r <= 2'd0;
        end else if (wr_hs_s) begin
            fill_cnt_r <= wr_last ? 2'd0 : fill_cnt_r + 2'd1;
        end else begin
            fill_cnt_r <= fill_cnt_r;
        end
    end

    // Starvation counter: counts blocked fill cycles, saturates, clears on any accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_r <= '0;
        end else if (wr_hs_s) begin
            starve_cnt_r <= '0;
        end else if (wr_vld && !starve_hold_s) begin
            starve_cnt_r <= starve_cnt_r + SW'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Read sideband follows the SRAM's one-cycle read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_r    <= 1'b0;
            out_beat_r   <= 2'd0;
            out_last_r   <= 1'b0;
            out_tag_r    <= '0;
            done_entry_r <= '0;
        end else begin
            out_vld_r    <= iss_vld_s;
            out_beat_r   <= iss_beat_s;
            out_last_r   <= iss_vld_s && iss_last_s;
            out_tag_r    <= iss_tag_s;
            done_entry_r <= iss_entry_s;
        end
    end

    lfdb_entry_alloc #(
        .ENTRY_NUM (ENTRY_NUM),
        .EW        (EW)
    ) u_alloc (
        .clk         (clk),
        .rst         (rst),
        .alloc_vld   (alloc_vld),
        .alloc_idx   (alloc_idx),
        .alloc_rdy   (alloc_rdy),
        .fill_vld    (wr_hs_s),
        .fill_entry  (wr_entry),
        .fill_last   (wr_last),
        .drain_vld   (rd_ok_s),
        .drain_entry (rd_entry),
        .free_vld    (out_last_r),
        .free_entry  (done_entry_r),
        .state       (entry_state),
        .free_cnt    (free_cnt)
    );

    lfdb_port_sched_chk u_chk (
        .clk      (clk),
        .rst      (rst),
        .wr_hs    (wr_hs_s),
        .wr_last  (wr_last),
        .fill_cnt (fill_cnt_r),
        .wr_state (wr_state_s)
    );

endmodule

// File: tb/tb_lfdb_port_sched.sv
// -----------------------------------------------------------------------------
// tb_lfdb_port_sched
// Directed bench for lfdb_port_sched (ENTRY_NUM=8, TAG_W=6, STARVE_MAX=8).
// Inputs change at the falling edge; outputs are sampled 1 time unit later,
// well away from the rising edge. Build with LFDB_SCHED_CRIT_FIRST_EN to
// include the critical-beat-first sequence.
// -----------------------------------------------------------------------------
module tb_lfdb_port_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_vld;
    logic [2:0] alloc_idx;
    logic       alloc_rdy;
    logic       wr_vld;
    logic [2:0] wr_entry;
    logic       wr_last;
    logic       wr_rdy;
    logic       rd_vld;
    logic [2:0] rd_entry;
    logic [5:0] rd_tag;
`ifdef LFDB_SCHED_CRIT_FIRST_EN
    logic [1:0] rd_beat;
`endif
    logic       rd_rdy;
    logic       mem_en;
    logic       mem_wr_en;
    logic [4:0] mem_addr;
    logic       out_vld;
    logic [1:0] out_beat;
    logic       out_last;
    logic [5:0] out_tag;
    logic       fill_done;
    logic [2:0] fill_done_entry;
    logic       drain_done;
    logic [5:0] drain_done_tag;
    logic [3:0] free_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lfdb_port_sched dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_vld       (alloc_vld),
        .alloc_idx       (alloc_idx),
        .alloc_rdy       (alloc_rdy),
        .wr_vld          (wr_vld),
        .wr_entry        (wr_entry),
        .wr_last         (wr_last),
        .wr_rdy          (wr_rdy),
        .rd_vld          (rd_vld),
        .rd_entry        (rd_entry),
        .rd_tag          (rd_tag),
`ifdef LFDB_SCHED_CRIT_FIRST_EN
        .rd_beat         (rd_beat),
`endif
        .rd_rdy          (rd_rdy),
        .mem_en          (mem_en),
        .mem_wr_en       (mem_wr_en),
        .mem_addr        (mem_addr),
        .out_vld         (out_vld),
        .out_beat        (out_beat),
        .out_last        (out_last),
        .out_tag         (out_tag),
        .fill_done       (fill_done),
        .fill_done_entry (fill_done_entry),
        .drain_done      (drain_done),
        .drain_done_tag  (drain_done_tag),
        .free_cnt        (free_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle of stimulus: drive at the falling edge, settle, then return for checks.
    task automatic cyc(input logic a, input logic wv, input logic [2:0] we, input logic wl,
                       input logic rv, input logic [2:0] re, input logic [5:0] rt);
        @(negedge clk);
        alloc_rdy = a;
        wr_vld    = wv;
        wr_entry  = we;
        wr_last   = wl;
        rd_vld    = rv;
        rd_entry  = re;
        rd_tag    = rt;
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 6'd0);
    endtask

    task automatic alloc_one(input int exp_idx, input int exp_cnt);
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 6'd0);
        check("alloc_vld", 32'(alloc_vld), 1);
        check("alloc_idx", 32'(alloc_idx), exp_idx);
        check("alloc_free_cnt", 32'(free_cnt), exp_cnt);
    endtask

    task automatic fill_beats(input logic [2:0] e, input int first);
        for (int b = first; b < 4; b++) begin
            cyc(1'b0, 1'b1, e, (b == 3), 1'b0, 3'd0, 6'd0);
            check("fill_wr_rdy", 32'(wr_rdy), 1);
            check("fill_mem_wr_en", 32'(mem_wr_en), 1);
            check("fill_mem_addr", 32'(mem_addr), int'(e) * 4 + b);
            check("fill_done", 32'(fill_done), (b == 3) ? 1 : 0);
            check("fill_done_entry", 32'(fill_done_entry), (b == 3) ? int'(e) : 0);
        end
    endtask

    task automatic drain(input logic [2:0] e, input logic [5:0] t);
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, e, t);
                check("drain_rd_rdy", 32'(rd_rdy), 1);
            end else begin
                idle();
            end
            check("drain_mem_en", 32'(mem_en), (k < 4) ? 1 : 0);
            check("drain_mem_wr_en", 32'(mem_wr_en), 0);
            check("drain_mem_addr", 32'(mem_addr), (k < 4) ? int'(e) * 4 + k : 0);
            check("drain_out_vld", 32'(out_vld), (k >= 1) ? 1 : 0);
            check("drain_out_beat", 32'(out_beat), (k >= 1) ? k - 1 : 0);
            check("drain_out_last", 32'(out_last), (k == 4) ? 1 : 0);
            check("drain_done", 32'(drain_done), (k == 4) ? 1 : 0);
            check("drain_done_tag", 32'(drain_done_tag), (k == 4) ? int'(t) : 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        alloc_rdy = 1'b0;
        wr_vld    = 1'b0;
        wr_entry  = 3'd0;
        wr_last   = 1'b0;
        rd_vld    = 1'b0;
        rd_entry  = 3'd0;
        rd_tag    = 6'd0;
`ifdef LFDB_SCHED_CRIT_FIRST_EN
        rd_beat   = 2'd0;
`endif
        repeat (2) @(negedge clk);
        #1;
        check("rst_alloc_vld", 32'(alloc_vld), 1);
        check("rst_alloc_idx", 32'(alloc_idx), 0);
        check("rst_free_cnt", 32'(free_cnt), 8);
        check("rst_wr_rdy", 32'(wr_rdy), 0);
        check("rst_rd_rdy", 32'(rd_rdy), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_mem_wr_en", 32'(mem_wr_en), 0);
        check("rst_out_vld", 32'(out_vld), 0);
        check("rst_drain_done", 32'(drain_done), 0);
        check("rst_fill_done", 32'(fill_done), 0);
        rst = 1'b0;

        // Allocate three entries, fill entry 0, drain it with tag 0x15.
        alloc_one(0, 8);
        alloc_one(1, 7);
        alloc_one(2, 6);
        fill_beats(3'd0, 0);
        idle();
        check("fill_free_cnt", 32'(free_cnt), 5);
        drain(3'd0, 6'h15);
        idle();
        check("drain_free_cnt", 32'(free_cnt), 6);
        check("drain_realloc_idx", 32'(alloc_idx), 0);

        // Drain request on an entry that is still filling waits for fill_done.
        for (int b = 0; b < 4; b++) begin
            cyc(1'b0, 1'b1, 3'd1, (b == 3), 1'b1, 3'd1, 6'h2A);
            check("filling_rd_rdy", 32'(rd_rdy), 0);
            check("filling_wr_rdy", 32'(wr_rdy), 1);
            check("filling_mem_addr", 32'(mem_addr), 4 + b);
            check("filling_fill_done", 32'(fill_done), (b == 3) ? 1 : 0);
        end
        drain(3'd1, 6'h2A);
        idle();
        check("filling_free_cnt", 32'(free_cnt), 7);

        // Prepare entries 0,1,2 FULL and entry 3 ALLOC for the starvation run.
        fill_beats(3'd2, 0);
        alloc_one(0, 7);
        alloc_one(1, 6);
        fill_beats(3'd0, 0);
        fill_beats(3'd1, 0);
        alloc_one(3, 5);

        // Back-to-back bursts with a fill beat pending: after 8 blocked cycles
        // the third burst waits for one fill beat to go through.
        for (int s = 0; s < 10; s++) begin
            cyc(1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 3'((s < 4) ? 0 : ((s < 8) ? 1 : 2)), 6'h3C);
            check("starve_rd_rdy", 32'(rd_rdy), (s == 0 || s == 4 || s == 9) ? 1 : 0);
            check("starve_wr_rdy", 32'(wr_rdy), (s == 8) ? 1 : 0);
            check("starve_mem_en", 32'(mem_en), 1);
            check("starve_mem_wr_en", 32'(mem_wr_en), (s == 8) ? 1 : 0);
            check("starve_mem_addr", 32'(mem_addr), (s < 8) ? s : ((s == 8) ? 12 : 8));
            check("starve_drain_done", 32'(drain_done), (s == 4 || s == 8) ? 1 : 0);
        end
        for (int s = 10; s < 14; s++) begin
            idle();
            check("starve_tail_mem_en", 32'(mem_en), (s < 13) ? 1 : 0);
            check("starve_tail_addr", 32'(mem_addr), (s < 13) ? s - 1 : 0);
            check("starve_tail_done", 32'(drain_done), (s == 13) ? 1 : 0);
        end
        idle();
        check("starve_free_cnt", 32'(free_cnt), 7);
        fill_beats(3'd3, 1);

        // Exhaust the allocator, then free one entry through a drain.
        alloc_one(0, 7);
        alloc_one(1, 6);
        alloc_one(2, 5);
        alloc_one(4, 4);
        alloc_one(5, 3);
        alloc_one(6, 2);
        alloc_one(7, 1);
        idle();
        check("full_alloc_vld", 32'(alloc_vld), 0);
        check("full_free_cnt", 32'(free_cnt), 0);
        drain(3'd3, 6'h07);
        check("full_done_alloc_vld", 32'(alloc_vld), 0);
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 6'd0);
        check("freed_alloc_vld", 32'(alloc_vld), 1);
        check("freed_alloc_idx", 32'(alloc_idx), 3);
        check("freed_free_cnt", 32'(free_cnt), 1);
        idle();
        check("retaken_alloc_vld", 32'(alloc_vld), 0);

`ifdef LFDB_SCHED_CRIT_FIRST_EN
        // Critical beat first: start at beat 2, order 2,3,0,1, last on beat 1.
        fill_beats(3'd5, 0);
        rd_beat = 2'd2;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b0, 3'd0, 1'b0, (k == 0), 3'd5, 6'h11);
            check("crit_mem_en", 32'(mem_en), (k < 4) ? 1 : 0);
            check("crit_mem_addr", 32'(mem_addr), (k < 4) ? 20 + ((2 + k) % 4) : 0);
            check("crit_out_beat", 32'(out_beat), (k >= 1) ? ((1 + k) % 4) : 0);
            check("crit_out_last", 32'(out_last), (k == 4) ? 1 : 0);
            check("crit_drain_tag", 32'(drain_done_tag), (k == 4) ? 32'h11 : 0);
        end
        rd_beat = 2'd0;
        idle();
        check("crit_alloc_idx", 32'(alloc_idx), 5);
`endif

        // Reset in the middle of a burst aborts it without a done pulse.
        fill_beats(3'd0, 0);
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 6'h33);
        check("abort_rd_rdy", 32'(rd_rdy), 1);
        idle();
        check("abort_out_vld", 32'(out_vld), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_rst_out_vld", 32'(out_vld), 0);
        check("abort_rst_drain_done", 32'(drain_done), 0);
        check("abort_rst_mem_en", 32'(mem_en), 0);
        check("abort_rst_free_cnt", 32'(free_cnt), 8);
        check("abort_rst_alloc_vld", 32'(alloc_vld), 1);
        check("abort_rst_alloc_idx", 32'(alloc_idx), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idle();
            check("abort_post_drain_done", 32'(drain_done), 0);
            check("abort_post_out_vld", 32'(out_vld), 0);
            check("abort_post_free_cnt", 32'(free_cnt), 8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
